icache_fetch_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 4 KB instruction-cache address port among 32 thread processors. It owns the 5-bit select and enable of the 32:1 fetch-address multiplexer in front of the ICache. It runs a request/acknowledge handshake with the cache and returns a one-cycle completion strobe to the served processor. One transaction is in flight at a time; fairness comes from a rotating priority pointer.

---
 rtl/icache_fetch_arbiter_if.sv | 22 ++
 rtl/icache_fetch_arbiter.sv | 60 ++++++
 tb/tb_icache_fetch_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_arbiter_if.sv
// icache_fetch_arbiter_if: request/grant/cache handshake bundle between the fetch arbiter and its environment
interface icache_fetch_arbiter_if #(
  parameter int NUM_REQ = 32
);
  logic [NUM_REQ-1:0] req;
  logic               cache_ack;
  logic [4:0]         selectLine;
  logic               enable;
  logic               cache_req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic               timeout_err;
  logic               ack_err;
  modport master (
    input  req, cache_ack,
    output selectLine, enable, cache_req, grant, done, timeout_err, ack_err
  );
  modport slave (
    output req, cache_ack,
    input  selectLine, enable, cache_req, grant, done, timeout_err, ack_err
  );
endinterface

// File: rtl/icache_fetch_arbiter.sv
// icache_fetch_arbiter: round-robin sequencer sharing the ICache fetch-address port among 32 requesters
module icache_fetch_arbiter #(
  parameter int NUM_REQ = 32,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst_n,
  icache_fetch_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, RELEASE} state_t;
  state_t             r_state, w_next;
  logic [4:0]         r_ptr, r_sel, w_win, w_sel_next;
  logic [9:0]         r_cnt;
  logic [NUM_REQ-1:0] r_grant, r_done;
  logic               r_en, r_tmo, r_ack_err;
  logic               w_any, w_in_addr, w_ack, w_abort;
  always_comb begin
    w_win = r_ptr;
    // scanning from the farthest offset down leaves the nearest requester at or after ptr
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req[r_ptr + 5'(i)]) w_win = r_ptr + 5'(i);
    w_any      = |bus.req;
    w_in_addr  = r_state == ADDR;
    w_ack      = w_in_addr && bus.cache_ack;
    w_abort    = w_in_addr && !bus.cache_ack && r_cnt == 10'(TIMEOUT - 1);
    w_next     = r_state == IDLE ? (w_any ? ADDR : IDLE) :
                 r_state == ADDR ? (w_ack || w_abort ? RELEASE : ADDR) : IDLE;
    w_sel_next = r_state == IDLE && w_any ? w_win : r_sel;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_en      <= 1'b0;
      r_grant   <= '0;
      r_done    <= '0;
      r_tmo     <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sel     <= w_sel_next;
      r_cnt     <= w_in_addr && w_next == ADDR ? r_cnt + 10'd1 : 10'd0;
      r_ptr     <= r_state == RELEASE ? r_sel + 5'd1 : r_ptr;
      r_en      <= w_next == ADDR;
      r_grant   <= w_next == ADDR ? NUM_REQ'(1) << w_sel_next : '0;
      r_done    <= w_ack ? NUM_REQ'(1) << r_sel : '0;
      r_tmo     <= w_abort;
      r_ack_err <= r_ack_err | (bus.cache_ack && !w_in_addr);
    end
  end
  assign bus.selectLine  = r_sel;
  assign bus.enable      = r_en;
  assign bus.cache_req   = r_en;
  assign bus.grant       = r_grant;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_tmo;
  assign bus.ack_err     = r_ack_err;
endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// tb_icache_fetch_arbiter: directed and randomized checks of the fetch arbiter against a transaction-level model
module tb_icache_fetch_arbiter;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  icache_fetch_arbiter_if #(.NUM_REQ(32)) bus();
  icache_fetch_arbiter #(.NUM_REQ(32), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // model: phase 0 waiting, 1 address presented, 2 completion/abort cycle
  int m_ph, m_owner, m_ptr, m_age;
  bit m_ok, m_ackerr;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_ph = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_ok = 0; m_ackerr = 0;
  endtask
  task automatic model_step();
    int found;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (bus.cache_ack && m_ph != 1) m_ackerr = 1;
    if (m_ph == 0) begin
      found = -1;
      for (int k = 0; k < 32; k++)
        if (found < 0 && bus.req[(m_ptr + k) % 32]) found = (m_ptr + k) % 32;
      if (found >= 0) begin
        m_owner = found; m_ph = 1; m_age = 0;
      end
    end else if (m_ph == 1) begin
      m_age++;
      if (bus.cache_ack) begin m_ph = 2; m_ok = 1; end
      else if (m_age == TMO) begin m_ph = 2; m_ok = 0; end
    end else begin
      m_ptr = (m_owner + 1) % 32;
      m_ph = 0;
    end
  endtask
  always @(negedge clk) begin
    chk("model_grant", 64'(bus.grant), m_ph == 1 ? 64'(1) << m_owner : 64'(0));
    chk("model_done", 64'(bus.done), m_ph == 2 && m_ok ? 64'(1) << m_owner : 64'(0));
    chk("model_ctl", 64'({bus.selectLine, bus.enable, bus.cache_req, bus.timeout_err, bus.ack_err}),
        64'({5'(m_owner), m_ph == 1, m_ph == 1, m_ph == 2 && !m_ok, m_ackerr}));
  end
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_ctl", 64'({bus.enable, bus.cache_req, bus.timeout_err, bus.ack_err}), 64'(0));
    chk("rst_async_grant_done", {bus.grant, bus.done}, 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  // drives one transaction from the IDLE cycle; ack in ADDR cycle ack_at (0 = never)
  task automatic run_txn(input int ack_at, output int sel, output int n, output logic [31:0] g);
    tick();
    chk("addr_entry", 64'(bus.enable), 64'(1));
    sel = int'(bus.selectLine);
    g = bus.grant;
    n = 0;
    while (bus.enable && n < 40) begin
      n++;
      bus.cache_ack = (n == ack_at);
      tick();
    end
    bus.cache_ack = 1'b0;
  endtask
  int sel, n;
  logic [31:0] g, r;
  initial begin
    bus.req = '0;
    bus.cache_ack = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_ctl", 64'({bus.selectLine, bus.enable, bus.cache_req, bus.timeout_err, bus.ack_err}), 64'(0));
    chk("rst_grant_done", {bus.grant, bus.done}, 64'(0));
    bus.cache_ack = 1'b1;
    tick();
    bus.cache_ack = 1'b0;
    chk("ack_err_set", 64'(bus.ack_err), 64'(1));
    repeat (3) tick();
    chk("ack_err_sticky", 64'(bus.ack_err), 64'(1));
    chk("ack_err_no_grant", 64'(bus.enable), 64'(0));
    apply_reset();
    chk("ack_err_cleared", 64'(bus.ack_err), 64'(0));
    bus.req = 32'h20;
    run_txn(3, sel, n, g);
    chk("single_sel", 64'(sel), 64'(5));
    chk("single_grant", 64'(g), 64'h20);
    chk("single_len", 64'(n), 64'(3));
    chk("single_done", 64'(bus.done), 64'h20);
    bus.req = '0;
    tick();
    chk("single_done_pulse", 64'(bus.done), 64'(0));
    apply_reset();
    bus.req = '1;
    for (int i = 0; i < 33; i++) begin
      run_txn(1, sel, n, g);
      chk("rr_sel", 64'(sel), 64'(i % 32));
      chk("rr_len", 64'(n), 64'(1));
      chk("rr_done", 64'(bus.done), 64'(1) << (i % 32));
      tick();
    end
    bus.req = 32'(1) << 30;
    run_txn(1, sel, n, g);
    chk("rot_first", 64'(sel), 64'(30));
    bus.req = (32'(1) << 2) | (32'(1) << 31);
    tick();
    run_txn(1, sel, n, g);
    chk("rot_31_first", 64'(sel), 64'(31));
    bus.req = 32'(1) << 2;
    tick();
    run_txn(1, sel, n, g);
    chk("rot_2_next", 64'(sel), 64'(2));
    bus.req = 32'(1) << 7;
    tick();
    run_txn(0, sel, n, g);
    chk("tmo_sel", 64'(sel), 64'(7));
    chk("tmo_len", 64'(n), 64'(TMO));
    chk("tmo_err", 64'(bus.timeout_err), 64'(1));
    chk("tmo_no_done", 64'(bus.done), 64'(0));
    bus.req = (32'(1) << 7) | (32'(1) << 9);
    tick();
    chk("tmo_pulse_once", 64'(bus.timeout_err), 64'(0));
    run_txn(1, sel, n, g);
    chk("tmo_ptr8", 64'(sel), 64'(9));
    bus.req = 32'(1) << 7;
    tick();
    run_txn(TMO, sel, n, g);
    chk("ack_last_len", 64'(n), 64'(TMO));
    chk("ack_last_done", 64'(bus.done), 64'(1) << 7);
    chk("ack_last_no_err", 64'(bus.timeout_err), 64'(0));
    bus.req = 32'(1) << 12;
    tick();
    tick();
    chk("mid_addr", 64'(bus.grant), 64'(1) << 12);
    tick();
    apply_reset();
    chk("mid_no_done", 64'(bus.done), 64'(0));
    bus.req = (32'(1) << 3) | (32'(1) << 12);
    run_txn(1, sel, n, g);
    chk("mid_sel", 64'(sel), 64'(3));
    chk("mid_done", 64'(bus.done), 64'(1) << 3);
    bus.req = '0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) apply_reset();
      r = bus.req;
      for (int b = 0; b < 32; b++) begin
        if (bus.done[b] || $urandom_range(63) == 0) r[b] = 1'b0;
        else if (!r[b] && $urandom_range(15) == 0) r[b] = 1'b1;
      end
      bus.req = r;
      bus.cache_ack = ($urandom_range(2) == 0);
      tick();
    end
    bus.cache_ack = 1'b0;
    bus.req = '0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
